red_pitaya_asg_seq_ctrl: RTL and testbench

RED_PITAYA_ASG_SEQ_CTRL -- requirements
Module: red_pitaya_asg_seq_ctrl

---
 rtl/red_pitaya_asg_pkg.sv | 45 ++++
 rtl/red_pitaya_asg_slot_bank.sv | 56 +++++
 rtl/red_pitaya_asg_seq_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_red_pitaya_asg_seq_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_asg_pkg.sv
// Shared register map, CTRL/STATUS bit positions and slot field widths for the
// arbitrary-signal-generator sequence controller.
package red_pitaya_asg_pkg;

    localparam int unsigned N_SLOT     = 4;
    localparam int unsigned SLOT_IDX_W = 2;
    localparam int unsigned AMP_W      = 14;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned PHASE_W    = 2;
    localparam int unsigned RDLY_W     = 32;
    localparam int unsigned FRAC_W     = 16;
    localparam int unsigned THR_W      = 3;
    localparam int unsigned FREE_W     = 3;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_AMP    = 8'h08;
    localparam logic [7:0] ADDR_DC     = 8'h0C;
    localparam logic [7:0] ADDR_START  = 8'h10;
    localparam logic [7:0] ADDR_END    = 8'h14;
    localparam logic [7:0] ADDR_STEP   = 8'h18;
    localparam logic [7:0] ADDR_CYC    = 8'h1C;
    localparam logic [7:0] ADDR_RDLY   = 8'h20;
    localparam logic [7:0] ADDR_PHASE  = 8'h24;
    localparam logic [7:0] ADDR_IRQ    = 8'h28;

    localparam int unsigned CTRL_COMMIT = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_TRIG   = 2;

    localparam int unsigned ST_WR_LSB   = 4;
    localparam int unsigned ST_RD_LSB   = 6;
    localparam int unsigned ST_OVF      = 8;
    localparam int unsigned ST_UND      = 9;
    localparam int unsigned ST_FREE_LSB = 10;

    localparam int unsigned RNUM_LSB   = 16;
    localparam int unsigned IRQ_EN_BIT = 31;

    // Number of empty slots given the valid mask.
    function automatic logic [FREE_W-1:0] free_slots(input logic [N_SLOT-1:0] v);
        return FREE_W'(N_SLOT) - (FREE_W'(v[0]) + FREE_W'(v[1]) + FREE_W'(v[2]) + FREE_W'(v[3]));
    endfunction

endpackage

// File: rtl/red_pitaya_asg_slot_bank.sv
// Four-entry slot store; one slot is overwritten per write strobe and all
// slots are presented as packed buses.
module red_pitaya_asg_slot_bank
    import red_pitaya_asg_pkg::*;
#(
    parameter int unsigned AW = 32
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [SLOT_IDX_W-1:0]       idx,
    input  logic [AMP_W-1:0]            amp,
    input  logic [AMP_W-1:0]            dc,
    input  logic [AW-1:0]               start_addr,
    input  logic [AW-1:0]               end_addr,
    input  logic [AW-1:0]               step,
    input  logic [CNT_W-1:0]            ncyc,
    input  logic [CNT_W-1:0]            rnum,
    input  logic [RDLY_W-1:0]           rdly,
    input  logic [PHASE_W-1:0]          phase,
    output logic [N_SLOT*AMP_W-1:0]     amp_all,
    output logic [N_SLOT*AMP_W-1:0]     dc_all,
    output logic [N_SLOT*AW-1:0]        start_all,
    output logic [N_SLOT*AW-1:0]        end_all,
    output logic [N_SLOT*AW-1:0]        step_all,
    output logic [N_SLOT*CNT_W-1:0]     ncyc_all,
    output logic [N_SLOT*CNT_W-1:0]     rnum_all,
    output logic [N_SLOT*RDLY_W-1:0]    rdly_all,
    output logic [N_SLOT*PHASE_W-1:0]   phase_all
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_all   <= '0;
            dc_all    <= '0;
            start_all <= '0;
            end_all   <= '0;
            step_all  <= '0;
            ncyc_all  <= '0;
            rnum_all  <= '0;
            rdly_all  <= '0;
            phase_all <= '0;
        end else if (we) begin
            amp_all[idx*AMP_W +: AMP_W]       <= amp;
            dc_all[idx*AMP_W +: AMP_W]        <= dc;
            start_all[idx*AW +: AW]           <= start_addr;
            end_all[idx*AW +: AW]             <= end_addr;
            step_all[idx*AW +: AW]            <= step;
            ncyc_all[idx*CNT_W +: CNT_W]      <= ncyc;
            rnum_all[idx*CNT_W +: CNT_W]      <= rnum;
            rdly_all[idx*RDLY_W +: RDLY_W]    <= rdly;
            phase_all[idx*PHASE_W +: PHASE_W] <= phase;
        end
    end

endmodule

// File: rtl/red_pitaya_asg_seq_ctrl.sv
// Sequence controller: staging registers, 4-slot ring with commit/free
// bookkeeping, overflow/underrun flags and refill interrupt.
module red_pitaya_asg_seq_ctrl
    import red_pitaya_asg_pkg::*;
#(
    parameter int unsigned RSZ   = 16,
    parameter int unsigned N_BUF = 4
)(
    input  logic                        dac_clk_i,
    input  logic                        dac_rst_i,
    input  logic [7:0]                  sys_addr_i,
    input  logic [31:0]                 sys_wdata_i,
    input  logic                        sys_wen_i,
    input  logic                        sys_ren_i,
    output logic [31:0]                 sys_rdata_o,
    output logic                        sys_ack_o,
    input  logic                        buf_done_i,
    output logic [14*N_BUF-1:0]         set_amp_all_o,
    output logic [14*N_BUF-1:0]         set_dc_all_o,
    output logic [(RSZ+16)*N_BUF-1:0]   set_start_all_o,
    output logic [(RSZ+16)*N_BUF-1:0]   set_end_all_o,
    output logic [(RSZ+16)*N_BUF-1:0]   set_step_all_o,
    output logic [16*N_BUF-1:0]         set_ncyc_all_o,
    output logic [16*N_BUF-1:0]         set_rnum_all_o,
    output logic [2*N_BUF-1:0]          set_phase_bits_all_o,
    output logic [32*N_BUF-1:0]         set_rdly_all_o,
    output logic                        set_rst_o,
    output logic                        trig_sw_o,
    output logic                        underrun_o,
    output logic                        irq_o
);

    localparam int unsigned AW = RSZ + FRAC_W;

    logic [AMP_W-1:0]      amp_q, dc_q;
    logic [AW-1:0]         start_q, end_q, step_q;
    logic [CNT_W-1:0]      ncyc_q, rnum_q;
    logic [RDLY_W-1:0]     rdly_q;
    logic [PHASE_W-1:0]    phase_q;
    logic [THR_W-1:0]      irq_thr_q;
    logic                  irq_en_q;
    logic [N_SLOT-1:0]     valid_q;
    logic [SLOT_IDX_W-1:0] wr_slot_q, rd_slot_q;
    logic                  overflow_q, underrun_q;

    logic                  ctrl_wr_c, status_wr_c, commit_c, flush_c, trig_c;
    logic [N_SLOT-1:0]     valid_freed_c, valid_nxt_c;
    logic [SLOT_IDX_W-1:0] rd_next_c;
    logic                  commit_ok_c, overflow_set_c, underrun_set_c, slot_we_c;
    logic [FREE_W-1:0]     free_cnt_c;
    logic [THR_W-1:0]      irq_thr_eff_c;
    logic [31:0]           rdata_c;

    assign ctrl_wr_c   = sys_wen_i && (sys_addr_i == ADDR_CTRL);
    assign status_wr_c = sys_wen_i && (sys_addr_i == ADDR_STATUS);
    assign commit_c    = ctrl_wr_c && sys_wdata_i[CTRL_COMMIT];
    assign flush_c     = ctrl_wr_c && sys_wdata_i[CTRL_FLUSH];
    assign trig_c      = ctrl_wr_c && sys_wdata_i[CTRL_TRIG];
    assign rd_next_c   = rd_slot_q + SLOT_IDX_W'(1);

    // Free is resolved before commit so a slot released this cycle can be refilled.
    always_comb begin
        valid_freed_c = valid_q;
        if (buf_done_i)
            valid_freed_c[rd_slot_q] = 1'b0;
        commit_ok_c    = commit_c && !valid_freed_c[wr_slot_q];
        overflow_set_c = commit_c && valid_freed_c[wr_slot_q];
        valid_nxt_c    = valid_freed_c;
        if (commit_ok_c)
            valid_nxt_c[wr_slot_q] = 1'b1;
        underrun_set_c = buf_done_i && !valid_nxt_c[rd_next_c];
    end

    assign slot_we_c     = commit_ok_c && !flush_c;
    assign free_cnt_c    = free_slots(valid_q);
    assign irq_thr_eff_c = (irq_thr_q == '0) ? THR_W'(1) : irq_thr_q;

    always_comb begin
        rdata_c = '0;
        case (sys_addr_i)
            ADDR_STATUS: begin
                rdata_c[N_SLOT-1:0]                     = valid_q;
                rdata_c[ST_WR_LSB +: SLOT_IDX_W]        = wr_slot_q;
                rdata_c[ST_RD_LSB +: SLOT_IDX_W]        = rd_slot_q;
                rdata_c[ST_OVF]                         = overflow_q;
                rdata_c[ST_UND]                         = underrun_q;
                rdata_c[ST_FREE_LSB +: FREE_W]          = free_cnt_c;
            end
            ADDR_AMP:   rdata_c = 32'(amp_q);
            ADDR_DC:    rdata_c = 32'(dc_q);
            ADDR_START: rdata_c = 32'(start_q);
            ADDR_END:   rdata_c = 32'(end_q);
            ADDR_STEP:  rdata_c = 32'(step_q);
            ADDR_CYC:   rdata_c = {rnum_q, ncyc_q};
            ADDR_RDLY:  rdata_c = rdly_q;
            ADDR_PHASE: rdata_c = 32'(phase_q);
            ADDR_IRQ: begin
                rdata_c[THR_W-1:0]  = irq_thr_q;
                rdata_c[IRQ_EN_BIT] = irq_en_q;
            end
            default:    rdata_c = '0;
        endcase
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            amp_q     <= '0;
            dc_q      <= '0;
            start_q   <= '0;
            end_q     <= '0;
            step_q    <= '0;
            ncyc_q    <= '0;
            rnum_q    <= '0;
            rdly_q    <= '0;
            phase_q   <= '0;
            irq_thr_q <= '0;
            irq_en_q  <= 1'b0;
        end else if (sys_wen_i) begin
            case (sys_addr_i)
                ADDR_AMP:   amp_q   <= sys_wdata_i[AMP_W-1:0];
                ADDR_DC:    dc_q    <= sys_wdata_i[AMP_W-1:0];
                ADDR_START: start_q <= sys_wdata_i[AW-1:0];
                ADDR_END:   end_q   <= sys_wdata_i[AW-1:0];
                ADDR_STEP:  step_q  <= sys_wdata_i[AW-1:0];
                ADDR_CYC: begin
                    ncyc_q <= sys_wdata_i[CNT_W-1:0];
                    rnum_q <= sys_wdata_i[RNUM_LSB +: CNT_W];
                end
                ADDR_RDLY:  rdly_q  <= sys_wdata_i;
                ADDR_PHASE: phase_q <= sys_wdata_i[PHASE_W-1:0];
                ADDR_IRQ: begin
                    irq_thr_q <= sys_wdata_i[THR_W-1:0];
                    irq_en_q  <= sys_wdata_i[IRQ_EN_BIT];
                end
                default: ;
            endcase
        end
    end

    // Ring bookkeeping; flush overrides any concurrent commit or free.
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            valid_q    <= '0;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else if (flush_c) begin
            valid_q    <= '0;
            wr_slot_q  <= '0;
            rd_slot_q  <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            valid_q <= valid_nxt_c;
            if (commit_ok_c)
                wr_slot_q <= wr_slot_q + SLOT_IDX_W'(1);
            if (buf_done_i)
                rd_slot_q <= rd_next_c;
            if (overflow_set_c)
                overflow_q <= 1'b1;
            else if (status_wr_c && sys_wdata_i[ST_OVF])
                overflow_q <= 1'b0;
            if (underrun_set_c)
                underrun_q <= 1'b1;
            else if (status_wr_c && sys_wdata_i[ST_UND])
                underrun_q <= 1'b0;
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            sys_ack_o   <= 1'b0;
            sys_rdata_o <= '0;
            set_rst_o   <= 1'b0;
            trig_sw_o   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            sys_ack_o   <= sys_wen_i || sys_ren_i;
            sys_rdata_o <= sys_ren_i ? rdata_c : '0;
            set_rst_o   <= flush_c;
            trig_sw_o   <= trig_c;
            irq_o       <= irq_en_q && (free_cnt_c >= FREE_W'(irq_thr_eff_c));
        end
    end

    assign underrun_o = underrun_q;

    red_pitaya_asg_slot_bank #(
        .AW (AW)
    ) u_slot_bank (
        .clk        (dac_clk_i),
        .rst        (dac_rst_i),
        .we         (slot_we_c),
        .idx        (wr_slot_q),
        .amp        (amp_q),
        .dc         (dc_q),
        .start_addr (start_q),
        .end_addr   (end_q),
        .step       (step_q),
        .ncyc       (ncyc_q),
        .rnum       (rnum_q),
        .rdly       (rdly_q),
        .phase      (phase_q),
        .amp_all    (set_amp_all_o),
        .dc_all     (set_dc_all_o),
        .start_all  (set_start_all_o),
        .end_all    (set_end_all_o),
        .step_all   (set_step_all_o),
        .ncyc_all   (set_ncyc_all_o),
        .rnum_all   (set_rnum_all_o),
        .rdly_all   (set_rdly_all_o),
        .phase_all  (set_phase_bits_all_o)
    );

endmodule

// File: tb/tb_red_pitaya_asg_seq_ctrl.sv
// Self-checking bench: directed scenarios plus randomized bus/buf_done traffic
// compared against a slot-ring reference model.
module tb_red_pitaya_asg_seq_ctrl;

    localparam int RSZ = 16;
    localparam int NB  = 4;
    localparam int AW  = RSZ + 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        sys_addr;
    logic [31:0]       sys_wdata;
    logic              sys_wen, sys_ren;
    logic [31:0]       sys_rdata;
    logic              sys_ack;
    logic              buf_done;
    logic [14*NB-1:0]  amp_all, dc_all;
    logic [AW*NB-1:0]  start_all, end_all, step_all;
    logic [16*NB-1:0]  ncyc_all, rnum_all;
    logic [2*NB-1:0]   phase_all;
    logic [32*NB-1:0]  rdly_all;
    logic              set_rst, trig_sw, underrun, irq;

    red_pitaya_asg_seq_ctrl #(.RSZ(RSZ), .N_BUF(NB)) dut (
        .dac_clk_i            (clk),
        .dac_rst_i            (rst),
        .sys_addr_i           (sys_addr),
        .sys_wdata_i          (sys_wdata),
        .sys_wen_i            (sys_wen),
        .sys_ren_i            (sys_ren),
        .sys_rdata_o          (sys_rdata),
        .sys_ack_o            (sys_ack),
        .buf_done_i           (buf_done),
        .set_amp_all_o        (amp_all),
        .set_dc_all_o         (dc_all),
        .set_start_all_o      (start_all),
        .set_end_all_o        (end_all),
        .set_step_all_o       (step_all),
        .set_ncyc_all_o       (ncyc_all),
        .set_rnum_all_o       (rnum_all),
        .set_phase_bits_all_o (phase_all),
        .set_rdly_all_o       (rdly_all),
        .set_rst_o            (set_rst),
        .trig_sw_o            (trig_sw),
        .underrun_o           (underrun),
        .irq_o                (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: staging values, slot contents, ring occupancy.
    logic [13:0]   s_amp, s_dc;
    logic [AW-1:0] s_start, s_end, s_step;
    logic [15:0]   s_ncyc, s_rnum;
    logic [31:0]   s_rdly;
    logic [1:0]    s_ph;
    int            s_thr;
    bit            s_irqen;
    logic [13:0]   m_amp[4], m_dc[4];
    logic [AW-1:0] m_start[4], m_end[4], m_step[4];
    logic [15:0]   m_ncyc[4], m_rnum[4];
    logic [31:0]   m_rdly[4];
    logic [1:0]    m_ph[4];
    bit            m_valid[4];
    int            m_wr, m_rd;
    bit            m_ovf, m_und;

    task automatic model_reset();
        s_amp = '0; s_dc = '0; s_start = '0; s_end = '0; s_step = '0;
        s_ncyc = '0; s_rnum = '0; s_rdly = '0; s_ph = '0; s_thr = 0; s_irqen = 0;
        for (int i = 0; i < 4; i++) begin
            m_amp[i] = '0; m_dc[i] = '0; m_start[i] = '0; m_end[i] = '0; m_step[i] = '0;
            m_ncyc[i] = '0; m_rnum[i] = '0; m_rdly[i] = '0; m_ph[i] = '0; m_valid[i] = 0;
        end
        m_wr = 0; m_rd = 0; m_ovf = 0; m_und = 0;
    endtask

    function automatic int model_free();
        int n = 4;
        for (int i = 0; i < 4; i++) if (m_valid[i]) n--;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int st;
        case (a)
            8'h04: begin
                st = model_free() * 1024 + int'(m_und) * 512 + int'(m_ovf) * 256 + m_rd * 64 + m_wr * 16;
                for (int i = 0; i < 4; i++) if (m_valid[i]) st += (1 << i);
                return 32'(st);
            end
            8'h08: return 32'(s_amp);
            8'h0C: return 32'(s_dc);
            8'h10: return 32'(s_start);
            8'h14: return 32'(s_end);
            8'h18: return 32'(s_step);
            8'h1C: return {s_rnum, s_ncyc};
            8'h20: return s_rdly;
            8'h24: return 32'(s_ph);
            8'h28: return 32'(s_thr) | (s_irqen ? 32'h8000_0000 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_irq();
        int thr = (s_thr == 0) ? 1 : s_thr;
        return s_irqen && (model_free() >= thr);
    endfunction

    task automatic model_update(input bit wen, input logic [7:0] a, input logic [31:0] wd,
                                input bit done, output bit trig, output bit flush);
        bit commit = 0;
        trig = 0; flush = 0;
        if (wen) begin
            case (a)
                8'h00: begin commit = wd[0]; flush = wd[1]; trig = wd[2]; end
                8'h04: begin if (wd[8]) m_ovf = 0; if (wd[9]) m_und = 0; end
                8'h08: s_amp = wd[13:0];
                8'h0C: s_dc = wd[13:0];
                8'h10: s_start = wd[AW-1:0];
                8'h14: s_end = wd[AW-1:0];
                8'h18: s_step = wd[AW-1:0];
                8'h1C: begin s_ncyc = wd[15:0]; s_rnum = wd[31:16]; end
                8'h20: s_rdly = wd;
                8'h24: s_ph = wd[1:0];
                8'h28: begin s_thr = int'(wd[2:0]); s_irqen = wd[31]; end
                default: ;
            endcase
        end
        if (flush) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            m_wr = 0; m_rd = 0; m_ovf = 0; m_und = 0;
        end else begin
            if (done) begin
                m_valid[m_rd] = 0;
                m_rd = (m_rd + 1) % 4;
            end
            if (commit) begin
                if (m_valid[m_wr]) m_ovf = 1;
                else begin
                    m_amp[m_wr] = s_amp; m_dc[m_wr] = s_dc; m_start[m_wr] = s_start;
                    m_end[m_wr] = s_end; m_step[m_wr] = s_step; m_ncyc[m_wr] = s_ncyc;
                    m_rnum[m_wr] = s_rnum; m_rdly[m_wr] = s_rdly; m_ph[m_wr] = s_ph;
                    m_valid[m_wr] = 1;
                    m_wr = (m_wr + 1) % 4;
                end
            end
            if (done && !m_valid[m_rd]) m_und = 1;
        end
    endtask

    // One clock of stimulus, followed by checks of every observable output.
    task automatic cycle(input bit wen, input bit ren, input logic [7:0] a,
                         input logic [31:0] wd, input bit done);
        logic [31:0] exp_rd;
        bit exp_irq, exp_trig, exp_flush;
        logic [14*NB-1:0] e_amp, e_dc;
        logic [AW*NB-1:0] e_start, e_end, e_step;
        logic [16*NB-1:0] e_ncyc, e_rnum;
        logic [2*NB-1:0]  e_ph;
        logic [32*NB-1:0] e_rdly;
        exp_rd  = model_read(a);
        exp_irq = model_irq();
        sys_wen = wen; sys_ren = ren; sys_addr = a; sys_wdata = wd; buf_done = done;
        @(posedge clk); #1;
        sys_wen = 0; sys_ren = 0; buf_done = 0;
        model_update(wen, a, wd, done, exp_trig, exp_flush);
        for (int i = 0; i < 4; i++) begin
            e_amp[i*14 +: 14] = m_amp[i];   e_dc[i*14 +: 14] = m_dc[i];
            e_start[i*AW +: AW] = m_start[i]; e_end[i*AW +: AW] = m_end[i];
            e_step[i*AW +: AW] = m_step[i]; e_ncyc[i*16 +: 16] = m_ncyc[i];
            e_rnum[i*16 +: 16] = m_rnum[i]; e_ph[i*2 +: 2] = m_ph[i];
            e_rdly[i*32 +: 32] = m_rdly[i];
        end
        checks++;
        if (sys_ack !== (wen | ren)) begin
            errors++; $display("FAIL ack: got %b want %b", sys_ack, wen | ren);
        end
        if (ren) begin
            checks++;
            if (sys_rdata !== exp_rd) begin
                errors++; $display("FAIL rdata[%h]: got %h want %h", a, sys_rdata, exp_rd);
            end
        end
        checks++;
        if (trig_sw !== exp_trig) begin
            errors++; $display("FAIL trig_sw: got %b want %b", trig_sw, exp_trig);
        end
        checks++;
        if (set_rst !== exp_flush) begin
            errors++; $display("FAIL set_rst: got %b want %b", set_rst, exp_flush);
        end
        checks++;
        if (underrun !== m_und) begin
            errors++; $display("FAIL underrun: got %b want %b", underrun, m_und);
        end
        checks++;
        if (irq !== exp_irq) begin
            errors++; $display("FAIL irq: got %b want %b", irq, exp_irq);
        end
        checks++;
        if ({amp_all, dc_all, start_all, end_all, step_all, ncyc_all, rnum_all, phase_all, rdly_all}
            !== {e_amp, e_dc, e_start, e_end, e_step, e_ncyc, e_rnum, e_ph, e_rdly}) begin
            errors++;
            $display("FAIL slots: got %h want %h",
                     {amp_all, dc_all, start_all, end_all, step_all, ncyc_all, rnum_all, phase_all, rdly_all},
                     {e_amp, e_dc, e_start, e_end, e_step, e_ncyc, e_rnum, e_ph, e_rdly});
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1, 0, a, d, 0);
    endtask

    task automatic commit(input bit done);
        cycle(1, 0, 8'h00, 32'h1, done);
    endtask

    task automatic rd_status(output logic [31:0] v);
        cycle(0, 1, 8'h04, 32'h0, 0);
        v = sys_rdata;
    endtask

    task automatic test_reset();
        rst = 1; sys_wen = 0; sys_ren = 0; sys_addr = '0; sys_wdata = '0; buf_done = 0;
        model_reset();
        #12;
        checks++;
        if ({sys_ack, sys_rdata, set_rst, trig_sw, underrun, irq} !== 38'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {sys_ack, sys_rdata, set_rst, trig_sw, underrun, irq});
        end
        checks++;
        if ({amp_all, dc_all, start_all, end_all, step_all, ncyc_all, rnum_all, phase_all, rdly_all} !== '0) begin
            errors++; $display("FAIL reset_slots: got nonzero want 0");
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        begin
            logic [31:0] st;
            rd_status(st);
            checks++;
            if (st !== 32'h0000_1000) begin
                errors++; $display("FAIL reset_status: got %h want 00001000", st);
            end
        end
    endtask

    task automatic test_commit_first();
        logic [31:0] st;
        wr(8'h00, 32'h2);
        wr(8'h08, 32'h1000);
        wr(8'h18, 32'h10000);
        commit(0);
        checks++;
        if (amp_all[13:0] !== 14'h1000) begin
            errors++; $display("FAIL commit_amp: got %h want 1000", amp_all[13:0]);
        end
        checks++;
        if (step_all[AW-1:0] !== 32'h10000) begin
            errors++; $display("FAIL commit_step: got %h want 10000", step_all[AW-1:0]);
        end
        rd_status(st);
        checks++;
        if (st !== 32'h0000_0C11) begin
            errors++; $display("FAIL commit_status: got %h want 00000c11", st);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        wr(8'h00, 32'h2);
        wr(8'h08, 32'h0123);
        for (int i = 0; i < 4; i++) commit(0);
        wr(8'h08, 32'h0AAA);
        commit(0);
        checks++;
        if (amp_all[13:0] !== 14'h0123) begin
            errors++; $display("FAIL overflow_slot0: got %h want 0123", amp_all[13:0]);
        end
        rd_status(st);
        checks++;
        if (st !== 32'h0000_010F) begin
            errors++; $display("FAIL overflow_status: got %h want 0000010f", st);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] st;
        wr(8'h00, 32'h2);
        commit(0);
        cycle(0, 0, 8'h00, 32'h0, 1);
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_flag: got %b want 1", underrun);
        end
        rd_status(st);
        checks++;
        if (st !== 32'h0000_1250) begin
            errors++; $display("FAIL underrun_status: got %h want 00001250", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        wr(8'h00, 32'h2);
        wr(8'h08, 32'h0111);
        for (int i = 0; i < 4; i++) commit(0);
        wr(8'h08, 32'h0222);
        commit(1);
        checks++;
        if (amp_all[13:0] !== 14'h0222) begin
            errors++; $display("FAIL b2b_slot0: got %h want 0222", amp_all[13:0]);
        end
        rd_status(st);
        checks++;
        if (st !== 32'h0000_005F) begin
            errors++; $display("FAIL b2b_status: got %h want 0000005f", st);
        end
    endtask

    task automatic test_irq();
        wr(8'h00, 32'h2);
        wr(8'h28, 32'h8000_0002);
        for (int i = 0; i < 4; i++) commit(0);
        cycle(0, 0, 8'h00, 32'h0, 1);
        cycle(0, 0, 8'h00, 32'h0, 0);
        cycle(0, 0, 8'h00, 32'h0, 0);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_one_free: got %b want 0", irq);
        end
        cycle(0, 0, 8'h00, 32'h0, 1);
        cycle(0, 0, 8'h00, 32'h0, 0);
        cycle(0, 0, 8'h00, 32'h0, 0);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_two_free: got %b want 1", irq);
        end
    endtask

    task automatic test_flush();
        logic [31:0] st;
        wr(8'h00, 32'h2);
        for (int i = 0; i < 4; i++) commit(0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 32'h0, 1);
        commit(0);
        commit(0);
        rd_status(st);
        checks++;
        if (st[3:0] !== 4'b1011) begin
            errors++; $display("FAIL flush_pre_valid: got %b want 1011", st[3:0]);
        end
        wr(8'h00, 32'h2);
        checks++;
        if (set_rst !== 1'b1) begin
            errors++; $display("FAIL flush_pulse_hi: got %b want 1", set_rst);
        end
        rd_status(st);
        checks++;
        if (set_rst !== 1'b0) begin
            errors++; $display("FAIL flush_pulse_lo: got %b want 0", set_rst);
        end
        checks++;
        if (st !== 32'h0000_1000) begin
            errors++; $display("FAIL flush_status: got %h want 00001000", st);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [31:0] d;
        bit done;
        for (int n = 0; n < 3000; n++) begin
            done = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    a = 8'(8 + 4 * $urandom_range(0, 13));
                    cycle(1, 0, a, $urandom, done);
                end
                3, 4, 5: begin
                    d = $urandom & 32'hFFFF_FFFD;
                    if ($urandom_range(0, 15) == 0) d = d | 32'h2;
                    cycle(1, 0, 8'h00, d, done);
                end
                6: cycle(1, 0, 8'h04, $urandom, done);
                7: begin
                    a = 8'(4 * $urandom_range(0, 15));
                    cycle(0, 1, a, 32'h0, done);
                end
                8: cycle(0, 1, 8'h04, 32'h0, done);
                default: cycle(0, 0, 8'h00, 32'h0, done);
            endcase
        end
    endtask

    task automatic test_reset_mid_access();
        sys_wen = 1; sys_addr = 8'h08; sys_wdata = 32'h1555;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        checks++;
        if (sys_ack !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ack: got %b want 0", sys_ack);
        end
        sys_wen = 0;
        model_reset();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        cycle(0, 1, 8'h08, 32'h0, 0);
        checks++;
        if (sys_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_amp: got %h want 0", sys_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_commit_first();
        test_overflow();
        test_underrun();
        test_back_to_back();
        test_irq();
        test_flush();
        test_random();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
